// File: rtl/mmio_pkg.sv
// Shared register map, STATUS bit positions and window decode for the MMIO port responder.
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1001_0400;

    typedef enum logic [2:0] {
        OFF_PORTOUT   = 3'd0,
        OFF_PORTIN    = 3'd1,
        OFF_STATUS    = 3'd2,
        OFF_TMR_LOAD  = 3'd3,
        OFF_TMR_COUNT = 3'd4
    } reg_off_e;

    localparam int ST_IN_CHG  = 0;
    localparam int ST_IN_OVR  = 1;
    localparam int ST_TMR_EXP = 2;
    localparam int STATUS_W   = 3;

    // The window is 32 bytes, so only address bits [31:5] take part in the decode.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:5] == base[31:5];
    endfunction

endpackage

// File: rtl/mmio_down_timer.sv
// Auto-reloading down counter; expire flags the cycle whose edge performs the reload.
module mmio_down_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] reload,
    output logic [31:0] count,
    output logic        expire
);

    // A load in the same cycle pre-empts the reload, so it also suppresses the expiry event.
    assign expire = !load && (reload != 32'd0) && (count == 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            reload <= 32'd0;
            count  <= 32'd0;
        end else if (load) begin
            reload <= load_value;
            count  <= load_value;
        end else if (reload != 32'd0) begin
            if (count <= 32'd1)
                count <= reload;
            else
                count <= count - 32'd1;
        end
    end

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: output port, synchronized input port with change flags, interval timer.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int          IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    output logic [31:0]         ReadData,
    output logic                Hit,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    logic [2:0]          offset;
    logic                wr_en;
    logic                rd_en;
    logic [IN_WIDTH-1:0] sync_meta;
    logic [IN_WIDTH-1:0] sync_in;
    logic [IN_WIDTH-1:0] portin_reg;
    logic [STATUS_W-1:0] status;
    logic [STATUS_W-1:0] status_set;
    logic [STATUS_W-1:0] status_clr;
    logic                in_change;
    logic                tmr_load;
    logic [31:0]         tmr_reload;
    logic [31:0]         tmr_count;
    logic                tmr_expire;

    assign Hit    = in_window(Address, IO_BASE);
    assign offset = Address[4:2];
    assign wr_en  = MemWrite && Hit;
    assign rd_en  = MemRead && Hit;

    assign in_change = (sync_in != portin_reg);
    assign tmr_load  = wr_en && (offset == OFF_TMR_LOAD);

    always_comb begin
        status_set             = '0;
        status_set[ST_IN_CHG]  = in_change;
        status_set[ST_IN_OVR]  = in_change && status[ST_IN_CHG];
        status_set[ST_TMR_EXP] = tmr_expire;

        status_clr = '0;
        if (wr_en && (offset == OFF_STATUS))
            status_clr = WriteData[STATUS_W-1:0];
        if (rd_en && (offset == OFF_PORTIN))
            status_clr[ST_IN_CHG] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta  <= '0;
            sync_in    <= '0;
            portin_reg <= '0;
            status     <= '0;
            PortOut    <= 32'd0;
        end else begin
            sync_meta <= PortIn;
            sync_in   <= sync_meta;
            if (in_change)
                portin_reg <= sync_in;
            // Set events are OR-ed in after the clear so they win on a same-cycle collision.
            status <= (status & ~status_clr) | status_set;
            if (wr_en && (offset == OFF_PORTOUT))
                PortOut <= WriteData;
        end
    end

    mmio_down_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (WriteData),
        .reload     (tmr_reload),
        .count      (tmr_count),
        .expire     (tmr_expire)
    );

    assign Irq = |status;

    // Zero-latency read path for a single-cycle core; idle bus reads as 0.
    always_comb begin
        ReadData = 32'd0;
        if (rd_en) begin
            case (offset)
                OFF_PORTOUT:   ReadData = PortOut;
                OFF_PORTIN:    ReadData = 32'(portin_reg);
                OFF_STATUS:    ReadData = 32'(status);
                OFF_TMR_LOAD:  ReadData = tmr_reload;
                OFF_TMR_COUNT: ReadData = tmr_count;
                default:       ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: register-access vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_mmio_port_responder;

    localparam logic [31:0] B = 32'h1001_0400;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        Irq;

    int tests = 0;
    int fails = 0;

    mmio_port_responder #(.IO_BASE(B), .IN_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .Irq       (Irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[20];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends at a falling edge; samples combinational outputs before the rising edge.
    task automatic do_access(input logic we, input logic re, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output logic hit);
        Address   = addr;
        WriteData = wdata;
        MemWrite  = we;
        MemRead   = re;
        #1;
        rdata = ReadData;
        hit   = Hit;
        @(posedge clk);
        @(negedge clk);
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        h;
        do_access(1'b0, 1'b1, addr, 32'd0, r, h);
        check32(name, r, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic        h;
        do_access(1'b1, 1'b0, addr, data, r, h);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        h;
        logic [31:0] exp_cnt;

        vecs[0]  = '{"rst_portout",    1'b0, 1'b1, B + 32'h00, 32'h0,         32'h0,         1'b1};
        vecs[1]  = '{"rst_portin",     1'b0, 1'b1, B + 32'h04, 32'h0,         32'h0,         1'b1};
        vecs[2]  = '{"rst_status",     1'b0, 1'b1, B + 32'h08, 32'h0,         32'h0,         1'b1};
        vecs[3]  = '{"rst_tmr_load",   1'b0, 1'b1, B + 32'h0C, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{"rst_tmr_count",  1'b0, 1'b1, B + 32'h10, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{"wr_portout",     1'b1, 1'b0, B + 32'h00, 32'hDEADBEEF,  32'h0,         1'b1};
        vecs[6]  = '{"rd_portout",     1'b0, 1'b1, B + 32'h00, 32'h0,         32'hDEADBEEF,  1'b1};
        vecs[7]  = '{"no_strobe",      1'b0, 1'b0, B + 32'h00, 32'h0,         32'h0,         1'b1};
        vecs[8]  = '{"wr_off7",        1'b1, 1'b0, B + 32'h1C, 32'h12345678,  32'h0,         1'b1};
        vecs[9]  = '{"rd_off7",        1'b0, 1'b1, B + 32'h1C, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{"rd_off6",        1'b0, 1'b1, B + 32'h18, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{"rd_above_win",   1'b0, 1'b1, B + 32'h20, 32'h0,         32'h0,         1'b0};
        vecs[12] = '{"rd_below_win",   1'b0, 1'b1, B - 32'h04, 32'h0,         32'h0,         1'b0};
        vecs[13] = '{"wr_portin_ro",   1'b1, 1'b0, B + 32'h04, 32'hFFFFFFFF,  32'h0,         1'b1};
        vecs[14] = '{"rd_portin_ro",   1'b0, 1'b1, B + 32'h04, 32'h0,         32'h0,         1'b1};
        vecs[15] = '{"wr_count_ro",    1'b1, 1'b0, B + 32'h10, 32'h00000007,  32'h0,         1'b1};
        vecs[16] = '{"rd_count_ro",    1'b0, 1'b1, B + 32'h10, 32'h0,         32'h0,         1'b1};
        vecs[17] = '{"rd_byte_lane",   1'b0, 1'b1, B + 32'h03, 32'h0,         32'hDEADBEEF,  1'b1};
        vecs[18] = '{"wr_outside",     1'b1, 1'b0, B + 32'h20, 32'h11111111,  32'h0,         1'b0};
        vecs[19] = '{"rd_after_off7",  1'b0, 1'b1, B + 32'h00, 32'h0,         32'hDEADBEEF,  1'b1};

        reset = 1'b1; Address = 32'd0; WriteData = 32'd0;
        MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check32("rst_portout_pin", PortOut, 32'd0);
        check32("rst_irq", {31'd0, Irq}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            do_access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, r, h);
            check32({vecs[i].name, "_data"}, r, vecs[i].exp_rdata);
            check32({vecs[i].name, "_hit"}, {31'd0, h}, {31'd0, vecs[i].exp_hit});
        end
        check32("portout_pin", PortOut, 32'hDEADBEEF);

        // Input change: flag appears on the third edge after PortIn moves.
        PortIn = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check32("irq_before_sync", {31'd0, Irq}, 32'd0);
        @(posedge clk);
        @(negedge clk); #1;
        check32("irq_after_change", {31'd0, Irq}, 32'd1);
        rd_check("status_in_chg", B + 32'h08, 32'h1);
        rd_check("portin_5a", B + 32'h04, 32'h5A);
        rd_check("status_after_rd", B + 32'h08, 32'h0);
        #1;
        check32("irq_after_rd", {31'd0, Irq}, 32'd0);

        // Overrun and write-one-to-clear.
        PortIn = 8'h33; repeat (4) @(negedge clk);
        PortIn = 8'h44; repeat (4) @(negedge clk);
        rd_check("status_ovr", B + 32'h08, 32'h3);
        wr(B + 32'h08, 32'h3);
        rd_check("status_w1c_all", B + 32'h08, 32'h0);
        #1;
        check32("irq_w1c_all", {31'd0, Irq}, 32'd0);
        PortIn = 8'h55; repeat (4) @(negedge clk);
        PortIn = 8'h44; repeat (4) @(negedge clk);
        wr(B + 32'h08, 32'h1);
        rd_check("status_w1c_bit0", B + 32'h08, 32'h2);
        #1;
        check32("irq_ovr_only", {31'd0, Irq}, 32'd1);
        wr(B + 32'h08, 32'h2);
        rd_check("status_w1c_bit1", B + 32'h08, 32'h0);

        // PORTIN read lands on the same edge as a new change: set wins.
        PortIn = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_access(1'b0, 1'b1, B + 32'h04, 32'd0, r, h);
        check32("portin_old_value", r, 32'h44);
        rd_check("status_set_wins", B + 32'h08, 32'h1);
        rd_check("portin_77", B + 32'h04, 32'h77);
        rd_check("status_cleared", B + 32'h08, 32'h0);

        // Load wins over decrement.
        wr(B + 32'h0C, 32'd9);
        repeat (2) @(negedge clk);
        wr(B + 32'h0C, 32'd3);
        rd_check("tmr_load_wins", B + 32'h10, 32'd3);

        // Period-5 timer: count sequence, then expiry pulses with a standing W1C of TMR_EXP.
        wr(B + 32'h0C, 32'd5);
        Address = B + 32'h10; MemRead = 1'b1;
        #1;
        check32("tmr_count_init", ReadData, 32'd5);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            @(negedge clk); #1;
            exp_cnt = ((i % 5) == 0) ? 32'd5 : 32'(5 - (i % 5));
            check32($sformatf("tmr_count_e%0d", i), ReadData, exp_cnt);
            check32($sformatf("tmr_irq_e%0d", i), {31'd0, Irq}, {31'd0, (i >= 5)});
        end
        MemRead = 1'b0; Address = B + 32'h08; WriteData = 32'h4; MemWrite = 1'b1;
        for (int i = 8; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk); #1;
            check32($sformatf("tmr_exp_pulse_e%0d", i), {31'd0, Irq}, {31'd0, ((i % 5) == 0)});
        end
        MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
        wr(B + 32'h08, 32'h7);
        wr(B + 32'h0C, 32'd0);
        Address = B + 32'h10; MemRead = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk); #1;
            check32($sformatf("tmr_stopped_%0d", i), ReadData, 32'd0);
            check32($sformatf("tmr_stopped_irq_%0d", i), {31'd0, Irq}, 32'd0);
        end
        MemRead = 1'b0; Address = 32'd0;

        // Reset mid-count with a colliding PORTOUT store.
        PortIn = 8'h00; repeat (4) @(negedge clk);
        wr(B + 32'h08, 32'h7);
        wr(B + 32'h00, 32'h00001234);
        wr(B + 32'h0C, 32'd4);
        repeat (2) @(negedge clk);
        reset = 1'b1; Address = B; WriteData = 32'hFFFFFFFF; MemWrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
        #1;
        check32("mid_rst_portout", PortOut, 32'd0);
        check32("mid_rst_irq", {31'd0, Irq}, 32'd0);
        for (int i = 0; i < 5; i++)
            rd_check($sformatf("mid_rst_reg%0d", i), B + 32'(4 * i), 32'd0);
        repeat (6) @(negedge clk);
        rd_check("mid_rst_count_held", B + 32'h10, 32'd0);
        #1;
        check32("mid_rst_irq_held", {31'd0, Irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
